// File: rtl/wb_port_arb_if.sv
// Register-file write-port arbitration bus: pipeline writeback (A), buffered
// multi-cycle result (B), the granted write port and the decode interlock signals.
interface wb_port_arb_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          a_we;
  logic [AW-1:0] a_waddr;
  logic [DW-1:0] a_wdata;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_waddr;
  logic [DW-1:0] b_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic          stall_req;
  logic          err;

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    output b_ready, we, waddr, wdata, pend_valid, pend_addr, stall_req, err
  );

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    input  b_ready, we, waddr, wdata, pend_valid, pend_addr, stall_req, err
  );
endinterface

// File: rtl/wb_port_arb.sv
// Write-port arbiter: A wins with zero latency, B waits in a one-entry buffer with bounded wait.
// Optional WBARB_STAT_EN adds saturating grant/stall counters.
module wb_port_arb #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_port_arb_if.slave bus
`ifdef WBARB_STAT_EN
  ,
  output logic [15:0]  stat_bwr,
  output logic [15:0]  stat_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  localparam logic [3:0] CntLast = 4'(MAX_WAIT - 1);

  state_e        state_q;
  logic [AW-1:0] buf_addr_q;
  logic [DW-1:0] buf_data_q;
  logic [3:0]    cnt_q;
  logic          err_q;

  logic a_live, grant_a, grant_b, pend, err_set;

  assign a_live = bus.a_we && (bus.a_waddr != '0);
  assign pend   = (state_q != StIdle);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      StIdle:  grant_a = a_live;
      StWait: begin
        grant_a = a_live;
        grant_b = !a_live;
      end
      StForce: grant_b = 1'b1;
      default: ;
    endcase
  end

  // Any A write in FORCE is dropped; an A write to the buffered register breaks ordering.
  assign err_set = ((state_q == StForce) && bus.a_we) ||
                   (pend && bus.a_we && (bus.a_waddr == buf_addr_q));

  assign bus.we         = grant_a || grant_b;
  assign bus.waddr      = grant_b ? buf_addr_q : (grant_a ? bus.a_waddr : '0);
  assign bus.wdata      = grant_b ? buf_data_q : (grant_a ? bus.a_wdata : '0);
  assign bus.b_ready    = (state_q == StIdle);
  assign bus.pend_valid = pend;
  assign bus.pend_addr  = pend ? buf_addr_q : '0;
  assign bus.stall_req  = (state_q == StForce);
  assign bus.err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Results for r0 are accepted and thrown away.
          if (bus.b_valid && (bus.b_waddr != '0)) begin
            buf_addr_q <= bus.b_waddr;
            buf_data_q <= bus.b_wdata;
            cnt_q      <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (grant_b) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == CntLast) state_q <= StForce;
          end
        end
        StForce: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef WBARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bwr   <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_b && (stat_bwr != 16'hFFFF)) stat_bwr <= stat_bwr + 16'd1;
      if ((state_q == StForce) && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed test-plan steps, then random traffic
// compared each cycle against a queue-based model of the arbitration rules.
module tb_wb_port_arb;
  localparam int MaxWait = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arb_if #(.AW(5), .DW(32)) bus ();

`ifdef WBARB_STAT_EN
  logic [15:0] stat_bwr, stat_stall;
`endif

  wb_port_arb #(.AW(5), .DW(32), .MAX_WAIT(MaxWait)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WBARB_STAT_EN
    ,
    .stat_bwr   (stat_bwr),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t pend_q[$];
  int   losses;
  bit   m_err;
  int   m_bwr, m_stall;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    losses  = 0;
    m_err   = 1'b0;
    m_bwr   = 0;
    m_stall = 0;
  endtask

  // Compare all outputs against the model for the current inputs, then advance the model.
  task automatic model_cycle();
    bit has, frc, alive, ga, gb;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    has   = (pend_q.size() != 0);
    frc   = has && (losses == MaxWait);
    alive = bus.a_we && (bus.a_waddr != 5'd0);
    ga    = alive && !frc;
    gb    = has && (frc || !alive);
    e_addr = gb ? pend_q[0].addr : (ga ? bus.a_waddr : 5'd0);
    e_data = gb ? pend_q[0].data : (ga ? bus.a_wdata : 32'd0);
    chk("b_ready", bus.b_ready, !has);
    chk("we", bus.we, ga || gb);
    chk("waddr", bus.waddr, e_addr);
    chk("wdata", bus.wdata, e_data);
    chk("pend_valid", bus.pend_valid, has);
    chk("pend_addr", bus.pend_addr, has ? pend_q[0].addr : 5'd0);
    chk("stall_req", bus.stall_req, frc);
    chk("err", bus.err, m_err);
`ifdef WBARB_STAT_EN
    chk("stat_bwr", stat_bwr, m_bwr);
    chk("stat_stall", stat_stall, m_stall);
`endif
    if ((frc && bus.a_we) || (has && bus.a_we && bus.a_waddr == pend_q[0].addr)) m_err = 1'b1;
    if (gb) begin
      void'(pend_q.pop_front());
      losses = 0;
      if (m_bwr < 16'hFFFF) m_bwr++;
    end else if (has) begin
      losses++;
    end
    if (frc && m_stall < 16'hFFFF) m_stall++;
    if (!has && bus.b_valid && bus.b_waddr != 5'd0) begin
      pend_q.push_back('{addr: bus.b_waddr, data: bus.b_wdata});
      losses = 0;
    end
  endtask

  task automatic cycle(input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    @(negedge clk);
    bus.a_we    = awe;
    bus.a_waddr = aa;
    bus.a_wdata = ad;
    bus.b_valid = bv;
    bus.b_waddr = ba;
    bus.b_wdata = bd;
    #1;
    model_cycle();
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    bus.a_we    = 1'b0;
    bus.b_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", bus.we, 1'b0);
    chk("rst_pend_valid", bus.pend_valid, 1'b0);
    chk("rst_pend_addr", bus.pend_addr, 5'd0);
    chk("rst_stall", bus.stall_req, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic starve(input logic [4:0] breg);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, breg, 32'h7700_0000 | 32'(breg));
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      chk("starve_a_we", bus.we, 1'b1);
      chk("starve_a_addr", bus.waddr, i);
    end
    idle();
    chk("starve_stall", bus.stall_req, 1'b1);
    chk("starve_we", bus.we, 1'b1);
    chk("starve_addr", bus.waddr, breg);
    idle();
    chk("starve_unstall", bus.stall_req, 1'b0);
  endtask

  initial begin
    bus.a_we = 1'b0; bus.a_waddr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_waddr = '0; bus.b_wdata = '0;
    model_reset();
    #1;
    chk("init_pend_valid", bus.pend_valid, 1'b0);
    chk("init_stall", bus.stall_req, 1'b0);
    chk("init_err", bus.err, 1'b0);
    chk("init_we", bus.we, 1'b0);
    #11 rst_n = 1'b1;

    // Idle B
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("idle_b_ready0", bus.b_ready, 1'b1);
    idle();
    chk("idle_we", bus.we, 1'b1);
    chk("idle_waddr", bus.waddr, 5'd5);
    chk("idle_wdata", bus.wdata, 32'hDEADBEEF);
    chk("idle_pend1", bus.pend_valid, 1'b1);
    idle();
    chk("idle_pend2", bus.pend_valid, 1'b0);
    chk("idle_b_ready2", bus.b_ready, 1'b1);

    starve(5'd7);

    // Zero register
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    idle();
    chk("zero_pend", bus.pend_valid, 1'b0);
    chk("zero_we", bus.we, 1'b0);
    chk("zero_b_ready", bus.b_ready, 1'b1);
    cycle(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
    chk("zero_a_we", bus.we, 1'b0);

    // A write during FORCE
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    for (int i = 10; i < 14; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    chk("force_waddr", bus.waddr, 5'd3);
    chk("force_wdata", bus.wdata, 32'h33);
    idle();
    chk("force_err", bus.err, 1'b1);

    // Reset mid-operation
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC);
    cycle(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0);
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("rst_no_r12", bus.we && (bus.waddr == 5'd12), 1'b0);
    end

    // Collision with pending register
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    cycle(1'b1, 5'd9, 32'hA9, 1'b0, 5'd0, 32'd0);
    chk("coll_waddr", bus.waddr, 5'd9);
    chk("coll_wdata", bus.wdata, 32'hA9);
    chk("coll_pend_addr", bus.pend_addr, 5'd9);
    idle();
    chk("coll_err", bus.err, 1'b1);
    chk("coll_buf_addr", bus.waddr, 5'd9);
    chk("coll_buf_data", bus.wdata, 32'h99);

    // Starvation twice from clean reset
    @(negedge clk);
    pulse_reset();
    starve(5'd7);
    starve(5'd8);
`ifdef WBARB_STAT_EN
    chk("stat_bwr_2", stat_bwr, 16'd2);
    chk("stat_stall_2", stat_stall, 16'd2);
`endif

    // Random traffic, mostly protocol-abiding
    @(negedge clk);
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      logic awe, bv;
      logic [4:0] aa, ba;
      bit has;
      awe = 1'($urandom_range(0, 1));
      aa  = 5'($urandom_range(0, 7));
      bv  = 1'($urandom_range(0, 1));
      ba  = 5'($urandom_range(0, 7));
      has = (pend_q.size() != 0);
      if (has && losses == MaxWait && $urandom_range(0, 19) != 0) awe = 1'b0;
      if (has && aa == pend_q[0].addr && $urandom_range(0, 19) != 0) aa = 5'd0;
      cycle(awe, aa, $urandom, bv, ba, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
